// File: rtl/opb_simulink2ppc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : opb_simulink2ppc_pkg                                         |
// | Description : Shared constants for the Simulink-to-PPC OPB register block. |
// |               Holds the register word indices, CTRL bit positions and the  |
// |               slave FSM state encoding.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package opb_simulink2ppc_pkg;

   // Word index within the window, taken from byte-address bits [3:2]
   localparam logic [1:0] c_reg_data  = 2'd0;  // offset 0x0, read-only
   localparam logic [1:0] c_reg_ctrl  = 2'd1;  // offset 0x4, read/write
   localparam logic [1:0] c_reg_count = 2'd2;  // offset 0x8, read-only

   // CTRL register bit positions
   localparam int unsigned c_ctrl_freeze_bit = 0;
   localparam int unsigned c_ctrl_new_bit    = 1;

   // Slave handshake state encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_HOLD = 2'd2
   } slv_state_e;

endpackage : opb_simulink2ppc_pkg
`default_nettype wire

// File: rtl/opb_slave_ack_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : opb_slave_ack_fsm                                            |
// | Description : OPB slave address decode and handshake FSM. Recognises a hit |
// |               on the slave window, captures the transfer attributes and    |
// |               produces a single-cycle registered xferAck.                  |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Ports                                                                      |
// |   clk_i       : bus clock                                                  |
// |   rst_n_i     : asynchronous active-low reset                              |
// |   select_i    : OPB_select                                                 |
// |   abus_i      : OPB address, bit 0 is the MSB                              |
// |   rnw_i       : 1 = read, 0 = write                                        |
// |   xfer_ack_o  : high for exactly the ACK cycle of a transfer               |
// |   rnw_o       : direction captured at the hit                              |
// |   reg_sel_o   : register word index captured at the hit                    |
// |   reg_valid_o : 1 when the hit landed on one of the mapped words           |
// +----------------------------------------------------------------------------+
module opb_slave_ack_fsm
   import opb_simulink2ppc_pkg::*;
#(
   parameter int unsigned                C_OPB_AWIDTH = 32,
   parameter logic [C_OPB_AWIDTH-1:0]    C_BASEADDR   = 32'h0108E600,
   parameter logic [C_OPB_AWIDTH-1:0]    C_HIGHADDR   = 32'h0108E6FF
)
(
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    select_i,
   input  logic [0:C_OPB_AWIDTH-1] abus_i,
   input  logic                    rnw_i,
   output logic                    xfer_ack_o,
   output logic                    rnw_o,
   output logic [1:0]              reg_sel_o,
   output logic                    reg_valid_o
);

   slv_state_e              state_q;
   logic                    xfer_ack_q;
   logic                    rnw_q;
   logic [1:0]              reg_sel_q;
   logic                    reg_valid_q;

   logic                    w_hit;
   logic [C_OPB_AWIDTH-1:0] w_offset;
   logic                    w_in_regs;

   assign w_hit     = select_i && (abus_i >= C_BASEADDR) && (abus_i <= C_HIGHADDR);
   assign w_offset  = abus_i - C_BASEADDR;
   // Only the first four words are decoded; anything above offset 0xF reads 0
   // even though bits [28:29] would alias onto a real register.
   assign w_in_regs = ((w_offset >> 4) == '0);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         xfer_ack_q  <= 1'b0;
         rnw_q       <= 1'b0;
         reg_sel_q   <= 2'd0;
         reg_valid_q <= 1'b0;
      end else begin
         xfer_ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (w_hit) begin
                  state_q     <= ST_ACK;
                  xfer_ack_q  <= 1'b1;
                  rnw_q       <= rnw_i;
                  reg_sel_q   <= abus_i[C_OPB_AWIDTH-4 +: 2];
                  reg_valid_q <= w_in_regs;
               end
            end
            // HOLD is always visited so a master that drops select during
            // ACK cannot trigger a second acknowledge on the same cycle.
            ST_ACK:  state_q <= ST_HOLD;
            ST_HOLD: begin
               if (!select_i) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign xfer_ack_o  = xfer_ack_q;
   assign rnw_o       = rnw_q;
   assign reg_sel_o   = reg_sel_q;
   assign reg_valid_o = reg_valid_q;

endmodule : opb_slave_ack_fsm
`default_nettype wire

// File: rtl/opb_register_simulink2ppc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : opb_register_simulink2ppc                                    |
// | Description : OPB slave publishing a fabric value to the PowerPC. Holds    |
// |               DATA (RO), CTRL (freeze / sticky new) and an update COUNT.   |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Ports                                                                      |
// |   OPB_Clk/OPB_Rst : clock and asynchronous active-low reset                |
// |   OPB_*           : OPB slave inputs (big-endian bit numbering)            |
// |   Sl_*            : OPB slave outputs; Sl_DBus is 0 outside read ACK       |
// |   user_data_in    : fabric value, loaded when user_valid and not frozen    |
// |   user_valid      : update strobe                                          |
// |   user_frozen     : copy of CTRL.freeze                                    |
// +----------------------------------------------------------------------------+
module opb_register_simulink2ppc
   import opb_simulink2ppc_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h0108E600,
   parameter logic [31:0] C_HIGHADDR   = 32'h0108E6FF,
   parameter int unsigned C_OPB_AWIDTH = 32,
   parameter int unsigned C_OPB_DWIDTH = 32,
   parameter              C_FAMILY     = "virtex5"
)
(
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
   input  logic [0:3]              OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
   input  logic                    OPB_RNW,
   input  logic                    OPB_select,
   input  logic                    OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
   output logic                    Sl_xferAck,
   output logic                    Sl_errAck,
   output logic                    Sl_retry,
   output logic                    Sl_toutSup,
   input  logic [31:0]             user_data_in,
   input  logic                    user_valid,
   output logic                    user_frozen
);

   localparam int unsigned c_unused_family_bits = $bits(C_FAMILY);

   logic [31:0] data_q,   data_d;
   logic [31:0] count_q,  count_d;
   logic        freeze_q, freeze_d;
   logic        new_q,    new_d;

   logic        w_ack;
   logic        w_rnw;
   logic [1:0]  w_reg_sel;
   logic        w_reg_valid;
   logic [31:0] w_wdata;
   logic [31:0] w_rdata;
   logic        w_update;
   logic        w_ctrl_wr;
   logic        w_unused;

   opb_slave_ack_fsm #(
      .C_OPB_AWIDTH (C_OPB_AWIDTH),
      .C_BASEADDR   (C_BASEADDR),
      .C_HIGHADDR   (C_HIGHADDR)
   ) u_ack_fsm (
      .clk_i       (OPB_Clk),
      .rst_n_i     (OPB_Rst),
      .select_i    (OPB_select),
      .abus_i      (OPB_ABus),
      .rnw_i       (OPB_RNW),
      .xfer_ack_o  (w_ack),
      .rnw_o       (w_rnw),
      .reg_sel_o   (w_reg_sel),
      .reg_valid_o (w_reg_valid)
   );

   // Bus bit 31 is the LSB, so a straight vector copy keeps numeric value;
   // byte lane 3 therefore carries CTRL bits [7:0].
   assign w_wdata   = OPB_DBus;
   assign w_update  = user_valid && !freeze_q;
   assign w_ctrl_wr = w_ack && !w_rnw && w_reg_valid &&
                      (w_reg_sel == c_reg_ctrl) && OPB_BE[3];

   always_comb begin
      data_d   = data_q;
      count_d  = count_q;
      freeze_d = freeze_q;
      if (w_update) begin
         data_d  = user_data_in;
         count_d = count_q + 32'd1;
      end
      if (w_ctrl_wr) begin
         freeze_d = w_wdata[c_ctrl_freeze_bit];
      end
      // Set has priority over a simultaneous write-1-to-clear.
      new_d = w_update ||
              (new_q && !(w_ctrl_wr && w_wdata[c_ctrl_new_bit]));
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
      if (!OPB_Rst) begin
         data_q   <= 32'd0;
         count_q  <= 32'd0;
         freeze_q <= 1'b0;
         new_q    <= 1'b0;
      end else begin
         data_q   <= data_d;
         count_q  <= count_d;
         freeze_q <= freeze_d;
         new_q    <= new_d;
      end
   end

   // Read data reflects register contents at the start of ACK.
   always_comb begin
      w_rdata = 32'd0;
      if (w_reg_valid) begin
         case (w_reg_sel)
            c_reg_data:  w_rdata = data_q;
            c_reg_ctrl:  w_rdata = {30'd0, new_q, freeze_q};
            c_reg_count: w_rdata = count_q;
            default:     w_rdata = 32'd0;
         endcase
      end
   end

   assign Sl_DBus     = (w_ack && w_rnw) ? w_rdata : '0;
   assign Sl_xferAck  = w_ack;
   assign Sl_errAck   = 1'b0;
   assign Sl_retry    = 1'b0;
   assign Sl_toutSup  = 1'b0;
   assign user_frozen = freeze_q;

   assign w_unused = &{1'b0, OPB_seqAddr, OPB_BE[0:2], w_wdata[31:2]};

endmodule : opb_register_simulink2ppc
`default_nettype wire

// File: tb/tb_opb_register_simulink2ppc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_opb_register_simulink2ppc                                 |
// | Description : Directed self-checking bench for opb_register_simulink2ppc.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_opb_register_simulink2ppc;

   localparam logic [31:0] c_base = 32'h0108E600;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [0:31] abus = '0;
   logic [0:3]  be = '0;
   logic [0:31] dbus_w = '0;
   logic        rnw = 1'b0;
   logic        sel = 1'b0;
   logic        seq = 1'b0;
   logic [0:31] sl_dbus;
   logic        sl_ack;
   logic        sl_err;
   logic        sl_retry;
   logic        sl_tout;
   logic [31:0] udata = '0;
   logic        uvalid = 1'b0;
   logic        ufrozen;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   opb_register_simulink2ppc dut (
      .OPB_Clk      (clk),
      .OPB_Rst      (rst_n),
      .OPB_ABus     (abus),
      .OPB_BE       (be),
      .OPB_DBus     (dbus_w),
      .OPB_RNW      (rnw),
      .OPB_select   (sel),
      .OPB_seqAddr  (seq),
      .Sl_DBus      (sl_dbus),
      .Sl_xferAck   (sl_ack),
      .Sl_errAck    (sl_err),
      .Sl_retry     (sl_retry),
      .Sl_toutSup   (sl_tout),
      .user_data_in (udata),
      .user_valid   (uvalid),
      .user_frozen  (ufrozen)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Read: select held until ack (bounded), dropped in the ACK cycle.
   // Sl_DBus is OR-ed over every sampled cycle so stray drive is caught.
   task automatic opb_read(input logic [31:0] addr, input logic [31:0] exp,
                           input int exp_acks, input string tag);
      int          acks = 0;
      logic [31:0] got  = '0;
      @(negedge clk);
      abus = addr; rnw = 1'b1; sel = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         got = got | sl_dbus;
         if (sl_ack) begin
            acks++;
            sel = 1'b0; rnw = 1'b0;
         end
      end
      sel = 1'b0; rnw = 1'b0;
      check({tag, "_acks"}, acks, exp_acks);
      check(tag, got, exp);
   endtask

   // Write, optionally raising user_valid during the ACK cycle itself.
   task automatic opb_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] bes, input logic uv,
                            input logic [31:0] uv_data, input string tag);
      int acks = 0;
      @(negedge clk);
      abus = addr; dbus_w = data; be = bes; rnw = 1'b0; sel = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         uvalid = 1'b0;
         if (sl_ack) begin
            acks++;
            sel = 1'b0;
            if (uv) begin
               uvalid = 1'b1; udata = uv_data;
            end
         end
      end
      sel = 1'b0; be = '0; dbus_w = '0;
      check({tag, "_acks"}, acks, 1);
   endtask

   task automatic user_pulse(input logic [31:0] v);
      @(negedge clk);
      uvalid = 1'b1; udata = v;
      @(negedge clk);
      uvalid = 1'b0;
   endtask

   initial begin
      // Reset held
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack",    {31'd0, sl_ack}, 32'd0);
      check("rst_dbus",   sl_dbus, 32'd0);
      check("rst_frozen", {31'd0, ufrozen}, 32'd0);
      check("const_outs", {29'd0, sl_err, sl_retry, sl_tout}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      opb_read(c_base + 32'h0, 32'h0, 1, "rd_data_rst");
      opb_read(c_base + 32'h4, 32'h0, 1, "rd_ctrl_rst");
      opb_read(c_base + 32'h8, 32'h0, 1, "rd_count_rst");

      // First update
      user_pulse(32'hDEADBEEF);
      opb_read(c_base + 32'h0, 32'hDEADBEEF, 1, "rd_data_1");
      opb_read(c_base + 32'h8, 32'h1, 1, "rd_count_1");
      opb_read(c_base + 32'h4, 32'h2, 1, "rd_ctrl_1");

      // Freeze: update ignored
      opb_write(c_base + 32'h4, 32'h1, 4'hF, 1'b0, 32'h0, "wr_freeze");
      #1;
      check("frozen_on", {31'd0, ufrozen}, 32'd1);
      user_pulse(32'h12345678);
      opb_read(c_base + 32'h0, 32'hDEADBEEF, 1, "rd_data_frozen");
      opb_read(c_base + 32'h8, 32'h1, 1, "rd_count_frozen");
      opb_read(c_base + 32'h4, 32'h3, 1, "rd_ctrl_frozen");

      // Byte enable for lane 3 off: write has no effect
      opb_write(c_base + 32'h4, 32'h2, 4'hE, 1'b0, 32'h0, "wr_ctrl_nobe");
      opb_read(c_base + 32'h4, 32'h3, 1, "rd_ctrl_nobe");

      // Unfreeze; new stays set
      opb_write(c_base + 32'h4, 32'h0, 4'h1, 1'b0, 32'h0, "wr_unfreeze");
      opb_read(c_base + 32'h4, 32'h2, 1, "rd_ctrl_unfrz");
      check("frozen_off", {31'd0, ufrozen}, 32'd0);

      // W1C coinciding with an update: set wins
      opb_write(c_base + 32'h4, 32'h2, 4'hF, 1'b1, 32'hCAFEF00D, "wr_w1c_upd");
      opb_read(c_base + 32'h4, 32'h2, 1, "rd_ctrl_setwins");
      opb_read(c_base + 32'h0, 32'hCAFEF00D, 1, "rd_data_2");
      opb_read(c_base + 32'h8, 32'h2, 1, "rd_count_2");

      // Plain W1C clears new
      opb_write(c_base + 32'h4, 32'h2, 4'hF, 1'b0, 32'h0, "wr_w1c");
      opb_read(c_base + 32'h4, 32'h0, 1, "rd_ctrl_clr");

      // Writes to read-only registers are acked and ignored
      opb_write(c_base + 32'h0, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, "wr_data_ro");
      opb_write(c_base + 32'h8, 32'h00000077, 4'hF, 1'b0, 32'h0, "wr_count_ro");
      opb_read(c_base + 32'h0, 32'hCAFEF00D, 1, "rd_data_ro");
      opb_read(c_base + 32'h8, 32'h2, 1, "rd_count_ro");

      // COUNT wrap
      @(negedge clk);
      force dut.count_q = 32'hFFFFFFFF;
      @(negedge clk);
      release dut.count_q;
      opb_read(c_base + 32'h8, 32'hFFFFFFFF, 1, "rd_count_max");
      user_pulse(32'h00000055);
      opb_read(c_base + 32'h8, 32'h0, 1, "rd_count_wrap");
      opb_read(c_base + 32'h0, 32'h00000055, 1, "rd_data_3");

      // Unmapped in-window offsets and out-of-window addresses
      opb_read(c_base + 32'hC,   32'h0, 1, "rd_off_c");
      opb_read(c_base + 32'h10,  32'h0, 1, "rd_off_10");
      opb_read(c_base + 32'h100, 32'h0, 0, "rd_above");
      opb_read(c_base - 32'h4,   32'h0, 0, "rd_below");

      // Reset asserted during ACK aborts the transfer
      @(negedge clk);
      abus = c_base; rnw = 1'b1; sel = 1'b1;
      @(posedge clk); #1;
      check("mid_ack_seen", {31'd0, sl_ack}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ack",  {31'd0, sl_ack}, 32'd0);
      check("mid_rst_dbus", sl_dbus, 32'd0);
      sel = 1'b0; rnw = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      opb_read(c_base + 32'h0, 32'h0, 1, "rd_data_after_rst");
      opb_read(c_base + 32'h8, 32'h0, 1, "rd_count_after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_opb_register_simulink2ppc
`default_nettype wire

// File: doc/opb_register_simulink2ppc.md
OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- C_BASEADDR, 32'h0108E600, first byte address of the slave window.
- C_HIGHADDR, 32'h0108E6FF, last byte address of the slave window.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_FAMILY, "virtex5", target family string.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- OPB_Clk, in, 1, single clock for bus and user logic.
- OPB_Rst, in, 1, asynchronous active-low reset.
- OPB_ABus, in, [0:31], address.
- OPB_BE, in, [0:3], byte enables.
- OPB_DBus, in, [0:31], write data.
- OPB_RNW, in, 1, 1 = read, 0 = write.
- OPB_select, in, 1, bus cycle active.
- OPB_seqAddr, in, 1, sequential-address hint (ignored).
- Sl_DBus, out, [0:31], read data.
- Sl_xferAck, out, 1, transfer acknowledge.
- Sl_errAck, out, 1, error acknowledge.
- Sl_retry, out, 1, retry.
- Sl_toutSup, out, 1, timeout suppress.
- user_data_in, in, [31:0], fabric value to publish.
- user_valid, in, 1, strobe: user_data_in is valid this cycle.
- user_frozen, out, 1, mirrors the freeze control bit.

Function
REQ-003 Register map (byte offsets from C_BASEADDR): 0x0 DATA (RO), 0x4 CTRL (RW), 0x8 COUNT (RO); all other in-window offsets SHALL read 0.
REQ-004 A hit SHALL be defined as OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; decoding SHALL use OPB_ABus[28:29].
REQ-005 Slave FSM states SHALL be IDLE, ACK and HOLD.
- IDLE -> ACK on a hit.
- ACK -> HOLD unconditionally.
- HOLD -> IDLE when OPB_select=0.
REQ-006 Sl_xferAck SHALL be 1 only in ACK, giving exactly one pulse per transfer, one cycle after the hit is registered.
REQ-007 Sl_DBus SHALL carry the read data only in ACK with OPB_RNW=1, and SHALL be 0 otherwise, so it can be wired-OR onto the bus.
REQ-008 Sl_errAck, Sl_retry and Sl_toutSup SHALL be constant 0.
REQ-009 DATA update: when user_valid=1 and CTRL.freeze=0, DATA SHALL load user_data_in on the next edge and COUNT SHALL increment.
- COUNT is 32 bits and wraps from 0xFFFFFFFF to 0.
REQ-010 When CTRL.freeze=1, DATA and COUNT SHALL hold and user_valid SHALL be ignored.
REQ-011 CTRL layout:
- bit0 freeze (RW).
- bit1 new (sticky).
- bits 31:2 read 0.
REQ-012 CTRL.new SHALL be set on every DATA update and cleared by a write to CTRL with bit1=1 (write-1-to-clear).
REQ-013 If a DATA update and a W1C of new occur in the same cycle, new SHALL end at 1 (set wins).
REQ-014 Writes SHALL take effect in the ACK cycle, and only for bytes whose OPB_BE bit is 1; writes to DATA or COUNT SHALL be acknowledged and have no effect.
REQ-015 A read of DATA SHALL return the value registered at the start of ACK; an update in the same cycle becomes visible on the next read.
REQ-016 If OPB_select drops during ACK, the FSM SHALL still pass through HOLD and then return to IDLE with no second acknowledge.
REQ-017 user_frozen SHALL equal CTRL.freeze.

Reset
REQ-018 While OPB_Rst=0, the block SHALL asynchronously force FSM=IDLE, DATA=0, COUNT=0, CTRL=0, Sl_xferAck=0 and Sl_DBus=0.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer with no acknowledge.
REQ-020 Deassertion SHALL be synchronised externally; the first cycle after release SHALL accept a hit.

Structure
REQ-021 Register offsets, CTRL bit indices and FSM state encodings SHALL live in a shared package, opb_simulink2ppc_pkg.
REQ-022 A single sub-module, opb_slave_ack_fsm (hit decode, FSM, xferAck), is natural; the register file SHALL stay in the top module.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset release; read 0x0, 0x4, 0x8 -> 0, 0, 0 each, with exactly one xferAck per read.
- user_valid with 0xDEADBEEF; read DATA -> 0xDEADBEEF; COUNT -> 1; CTRL -> 0x2.
- Write CTRL=0x1 (freeze); user_valid with 0x12345678 -> DATA stays 0xDEADBEEF, COUNT stays 1, user_frozen=1.
- Write CTRL=0x2 together with a user_valid in the same cycle (freeze=0) -> CTRL.new reads 1; a second W1C with no update -> reads 0.
- Preload COUNT to 0xFFFFFFFF via 2^32-1 updates (or force); one more update -> COUNT=0.
- Read at C_BASEADDR+0x10 -> 0; address outside the window -> no xferAck and Sl_DBus=0.
